// File: rtl/png_chunk_ctrl_pkg.sv
// Shared types and constants for the PNG chunk sequencer.
//   DATA_WD/NUM_WD/SIZE_WD : stream word, byte-count code and length widths
//   INIT_CYC_DFLT          : default crc32_top init latency in cycles
//   state_e, word_t        : FSM encoding and output-stream word payload
package png_chunk_ctrl_pkg;

  localparam int unsigned DATA_WD       = 32;
  localparam int unsigned NUM_WD        = 2;
  localparam int unsigned SIZE_WD       = 32;
  localparam int unsigned INIT_CYC_DFLT = 10;

  localparam logic [NUM_WD-1:0]  NUM_FULL = 2'd3;

  localparam logic [DATA_WD-1:0] TYP_IHDR = 32'h4948_4452;
  localparam logic [DATA_WD-1:0] TYP_IDAT = 32'h4944_4154;
  localparam logic [DATA_WD-1:0] TYP_IEND = 32'h4945_4E44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_INIT,
    ST_TYP,
    ST_DAT,
    ST_WCRC,
    ST_CRC,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [DATA_WD-1:0] dat;
    logic [NUM_WD-1:0]  num;
    logic               lst;
  } word_t;

  // Valid-byte code (bytes-1) for a payload word given the bytes still to send.
  function automatic logic [NUM_WD-1:0] word_num(input logic [SIZE_WD-1:0] rem);
    return (rem >= SIZE_WD'(4)) ? NUM_FULL : NUM_WD'(rem - SIZE_WD'(1));
  endfunction

endpackage

// File: rtl/png_chunk_ctrl_if.sv
// Bus bundle of png_chunk_ctrl: chunk control, payload input stream,
// chunk output stream and the crc32_top side-channel.
//   slave  : the chunk controller's view
//   master : the environment's view (producer, packer, crc32_top)
interface png_chunk_ctrl_if;
  import png_chunk_ctrl_pkg::*;

  logic                 start_i;
  logic [SIZE_WD-1:0]   len_i;
  logic [DATA_WD-1:0]   typ_i;
  logic                 busy_o;
  logic                 done_o;

  logic                 pld_val_i;
  logic                 pld_rdy_o;
  logic [DATA_WD-1:0]   pld_dat_i;

  logic                 out_val_o;
  logic                 out_rdy_i;
  logic [DATA_WD-1:0]   out_dat_o;
  logic [NUM_WD-1:0]    out_num_o;
  logic                 out_lst_o;

  logic                 crc_start_o;
  logic                 crc_val_o;
  logic [DATA_WD-1:0]   crc_dat_o;
  logic [NUM_WD-1:0]    crc_num_o;
  logic                 crc_lst_o;
  logic                 crc_done_i;
  logic [DATA_WD-1:0]   crc_dat_i;

  modport slave (
    input  start_i, len_i, typ_i, pld_val_i, pld_dat_i, out_rdy_i, crc_done_i, crc_dat_i,
    output busy_o, done_o, pld_rdy_o, out_val_o, out_dat_o, out_num_o, out_lst_o,
           crc_start_o, crc_val_o, crc_dat_o, crc_num_o, crc_lst_o
  );

  modport master (
    output start_i, len_i, typ_i, pld_val_i, pld_dat_i, out_rdy_i, crc_done_i, crc_dat_i,
    input  busy_o, done_o, pld_rdy_o, out_val_o, out_dat_o, out_num_o, out_lst_o,
           crc_start_o, crc_val_o, crc_dat_o, crc_num_o, crc_lst_o
  );

endinterface

// File: rtl/png_chunk_ctrl_word_reg.sv
// One-deep registered val/rdy stage for the chunk output stream.
//   in_val/in_word/in_rdy_c : load side; in_rdy_c is combinational (zero-bubble)
//   out_val/out_word/out_rdy: registered output, held stable while stalled
module png_chunk_ctrl_word_reg
  import png_chunk_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  in_val,
  input  word_t in_word,
  output logic  in_rdy_c,
  output logic  out_val,
  input  logic  out_rdy,
  output word_t out_word
);

  logic  val_q, val_d;
  word_t word_q, word_d;

  // Accept a new word when empty or when the current one leaves this cycle.
  assign in_rdy_c = ~val_q | out_rdy;

  always_comb begin
    val_d  = val_q;
    word_d = word_q;
    if (in_val && in_rdy_c) begin
      val_d  = 1'b1;
      word_d = in_word;
    end else if (out_rdy) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      val_q  <= 1'b0;
      word_q <= '0;
    end else begin
      val_q  <= val_d;
      word_q <= word_d;
    end
  end

  assign out_val  = val_q;
  assign out_word = word_q;

endmodule

// File: rtl/png_chunk_ctrl.sv
// Sequences one PNG chunk (LEN, TYPE, payload, CRC) onto a 32b word stream
// and drives crc32_top with the TYPE and payload words.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : png_chunk_ctrl_if.slave (control, payload in, chunk out, crc32_top)
module png_chunk_ctrl
  import png_chunk_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYC = INIT_CYC_DFLT
) (
  input  logic               clk,
  input  logic               rstn,
  png_chunk_ctrl_if.slave    bus
);

  localparam int unsigned CNT_WD = $clog2(INIT_CYC + 1);

  state_e               state_q, state_d;
  logic [SIZE_WD-1:0]   len_q, len_d;
  logic [SIZE_WD-1:0]   rem_q, rem_d;
  logic [DATA_WD-1:0]   typ_q, typ_d;
  logic [DATA_WD-1:0]   crc_res_q, crc_res_d;
  logic [CNT_WD-1:0]    cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 crc_start_q, crc_start_d;
  logic                 crc_val_q, crc_val_d;
  logic [DATA_WD-1:0]   crc_dat_q, crc_dat_d;
  logic [NUM_WD-1:0]    crc_num_q, crc_num_d;
  logic                 crc_lst_q, crc_lst_d;

  logic                 wr_val;
  logic                 wr_rdy_c;
  word_t                wr_word;
  word_t                out_word;
  logic [NUM_WD-1:0]    pld_num;
  logic                 pld_last;

  assign pld_num  = word_num(rem_q);
  assign pld_last = (rem_q <= SIZE_WD'(4));

  // Next-state, word issue and CRC feed.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    typ_d       = typ_q;
    crc_res_d   = crc_res_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    crc_start_d = 1'b0;
    crc_val_d   = 1'b0;
    crc_dat_d   = crc_dat_q;
    crc_num_d   = crc_num_q;
    crc_lst_d   = 1'b0;
    wr_val      = 1'b0;
    wr_word     = '0;

    // Init-latency counter runs from the crc_start_o pulse and saturates.
    if ((state_q == ST_LEN || state_q == ST_INIT) && cnt_q != CNT_WD'(INIT_CYC))
      cnt_d = cnt_q + CNT_WD'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          len_d       = bus.len_i;
          rem_d       = bus.len_i;
          typ_d       = bus.typ_i;
          cnt_d       = '0;
          crc_start_d = 1'b1;
          state_d     = ST_LEN;
        end
      end
      ST_LEN: begin
        wr_val  = 1'b1;
        wr_word = '{dat: len_q, num: NUM_FULL, lst: 1'b0};
        if (wr_rdy_c) state_d = ST_INIT;
      end
      ST_INIT: begin
        // Leaving at INIT_CYC-2 lets the TYPE word reach crc32_top exactly
        // INIT_CYC cycles after the start pulse.
        if (cnt_q >= CNT_WD'(INIT_CYC - 2)) state_d = ST_TYP;
      end
      ST_TYP: begin
        wr_val  = 1'b1;
        wr_word = '{dat: typ_q, num: NUM_FULL, lst: 1'b0};
        if (wr_rdy_c) begin
          crc_val_d = 1'b1;
          crc_dat_d = typ_q;
          crc_num_d = NUM_FULL;
          crc_lst_d = (len_q == '0);
          state_d   = (len_q == '0) ? ST_WCRC : ST_DAT;
        end
      end
      ST_DAT: begin
        wr_val  = bus.pld_val_i;
        wr_word = '{dat: bus.pld_dat_i, num: pld_num, lst: 1'b0};
        if (bus.pld_val_i && wr_rdy_c) begin
          crc_val_d = 1'b1;
          crc_dat_d = bus.pld_dat_i;
          crc_num_d = pld_num;
          crc_lst_d = pld_last;
          rem_d     = rem_q - SIZE_WD'(pld_num) - SIZE_WD'(1);
          if (pld_last) state_d = ST_WCRC;
        end
      end
      ST_WCRC: begin
        if (bus.crc_done_i) begin
          crc_res_d = bus.crc_dat_i;
          state_d   = ST_CRC;
        end
      end
      ST_CRC: begin
        wr_val  = 1'b1;
        wr_word = '{dat: crc_res_q, num: NUM_FULL, lst: 1'b1};
        if (wr_rdy_c) state_d = ST_FIN;
      end
      ST_FIN: begin
        // The CRC word is the only word in the register here.
        if (bus.out_val_o && bus.out_rdy_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      typ_q       <= '0;
      crc_res_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_start_q <= 1'b0;
      crc_val_q   <= 1'b0;
      crc_dat_q   <= '0;
      crc_num_q   <= '0;
      crc_lst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      typ_q       <= typ_d;
      crc_res_q   <= crc_res_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crc_start_q <= crc_start_d;
      crc_val_q   <= crc_val_d;
      crc_dat_q   <= crc_dat_d;
      crc_num_q   <= crc_num_d;
      crc_lst_q   <= crc_lst_d;
    end
  end

  png_chunk_ctrl_word_reg u_word_reg (
    .clk      (clk),
    .rstn     (rstn),
    .in_val   (wr_val),
    .in_word  (wr_word),
    .in_rdy_c (wr_rdy_c),
    .out_val  (bus.out_val_o),
    .out_rdy  (bus.out_rdy_i),
    .out_word (out_word)
  );

  assign bus.out_dat_o   = out_word.dat;
  assign bus.out_num_o   = out_word.num;
  assign bus.out_lst_o   = out_word.lst;
  assign bus.pld_rdy_o   = (state_q == ST_DAT) & wr_rdy_c;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.crc_start_o = crc_start_q;
  assign bus.crc_val_o   = crc_val_q;
  assign bus.crc_dat_o   = crc_dat_q;
  assign bus.crc_num_o   = crc_num_q;
  assign bus.crc_lst_o   = crc_lst_q;

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// Scoreboard bench for png_chunk_ctrl with a behavioural crc32_top model.
module tb_png_chunk_ctrl;
  import png_chunk_ctrl_pkg::*;

  localparam time T_CLK = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  bit   rand_rdy = 1'b0;
  bit   prev_rstn = 1'b0;
  logic [34:0] exp_q[$];
  logic [7:0]  pbytes[$];

  always #(T_CLK/2) clk = ~clk;

  png_chunk_ctrl_if bus();

  png_chunk_ctrl u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] chunk_crc(input logic [31:0] typ);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) c = crc_byte(c, typ[31-8*i -: 8]);
    foreach (pbytes[i]) c = crc_byte(c, pbytes[i]);
    return ~c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted output word.
  initial forever begin
    logic [34:0] got, exp;
    @(negedge clk);
    if (!rstn && !prev_rstn) begin
      checks++;
      if (bus.busy_o || bus.done_o || bus.pld_rdy_o || bus.out_val_o || (|bus.out_dat_o) ||
          (|bus.out_num_o) || bus.out_lst_o || bus.crc_start_o || bus.crc_val_o ||
          (|bus.crc_dat_o) || (|bus.crc_num_o) || bus.crc_lst_o) begin
        errors++;
        $display("FAIL reset_outputs got busy=%0d val=%0d dat=%h crc_val=%0d crc_dat=%h exp all 0",
                 bus.busy_o, bus.out_val_o, bus.out_dat_o, bus.crc_val_o, bus.crc_dat_o);
      end
    end else if (rstn) begin
      if (bus.out_val_o && bus.out_rdy_i) begin
        got = {bus.out_dat_o, bus.out_num_o, bus.out_lst_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %h/%0d/%0d exp none", got[34:3], got[2:1], got[0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL out_word got %h/%0d/%0d exp %h/%0d/%0d",
                     got[34:3], got[2:1], got[0], exp[34:3], exp[2:1], exp[0]);
          end
        end
      end
      if (bus.done_o) begin
        done_cnt++;
        checks++;
        if (bus.busy_o) begin
          errors++;
          $display("FAIL done_busy got busy=%0d exp 0", bus.busy_o);
        end
      end
    end
    prev_rstn = rstn;
  end

  // crc32_top model: init latency check, byte-wise CRC, done 3 cycles after last word.
  initial begin
    logic [31:0] mcrc, fin;
    int pend;
    bit started, fed;
    time start_t;
    mcrc = '0; fin = '0; pend = 0; started = 0; fed = 0; start_t = 0;
    bus.crc_done_i = 1'b0;
    bus.crc_dat_i  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.crc_done_i = 1'b0;
        pend = 0; started = 0; fed = 0;
      end else begin
        bus.crc_done_i = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.crc_done_i = 1'b1;
            bus.crc_dat_i  = fin;
          end
        end
        if (bus.crc_start_o) begin
          mcrc = 32'hFFFF_FFFF; start_t = $time; started = 1; fed = 0;
        end
        if (bus.crc_val_o) begin
          if (!fed) begin
            checks++;
            if (!started || ($time - start_t) < INIT_CYC_DFLT * T_CLK) begin
              errors++;
              $display("FAIL init_latency got %0t exp >= %0d cycles", $time - start_t, INIT_CYC_DFLT);
            end
            fed = 1;
          end
          for (int i = 0; i <= int'(bus.crc_num_o); i++) mcrc = crc_byte(mcrc, bus.crc_dat_o[31-8*i -: 8]);
          if (bus.crc_lst_o) begin
            fin = ~mcrc; pend = 3; started = 0;
          end
        end
      end
    end
  end

  // Downstream ready: always 1 or a 50% coin per cycle.
  initial forever begin
    @(posedge clk);
    #1;
    bus.out_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start_chunk(input logic [31:0] typ);
    exp_q.push_back({32'(pbytes.size()), NUM_FULL, 1'b0});
    exp_q.push_back({typ, NUM_FULL, 1'b0});
    bus.len_i   = 32'(pbytes.size());
    bus.typ_i   = typ;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_payload(input int nsend, input bit bubble, input int poke);
    int n, nw;
    n  = pbytes.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw && w < nsend; w++) begin
      logic [31:0] word;
      int nb, t;
      word = '0;
      nb = (n - 4*w >= 4) ? 4 : n - 4*w;
      for (int b = 0; b < nb; b++) word[31-8*b -: 8] = pbytes[4*w+b];
      exp_q.push_back({word, 2'(nb - 1), 1'b0});
      bus.pld_dat_i = word;
      bus.pld_val_i = 1'b1;
      if (w == poke) begin
        bus.start_i = 1'b1;
        bus.len_i   = 32'd5;
        bus.typ_i   = TYP_IEND;
      end
      t = 0;
      @(negedge clk);
      while (!bus.pld_rdy_o && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        errors++;
        $display("FAIL pld_rdy_timeout got 0 exp 1");
      end
      @(posedge clk);
      #1;
      bus.pld_val_i = 1'b0;
      bus.start_i   = 1'b0;
      if (bubble) tick();
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL done_count got %0d exp 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_words got %0d exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_chunk(input logic [31:0] typ, input bit bubble, input int poke,
                           input logic [31:0] crc_exp);
    int d0;
    d0 = done_cnt;
    start_chunk(typ);
    send_payload(pbytes.size(), bubble, poke);
    exp_q.push_back({crc_exp, NUM_FULL, 1'b1});
    wait_done(d0);
  endtask

  initial begin
    #(T_CLK * 50000);
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start_i   = 1'b0;
    bus.len_i     = '0;
    bus.typ_i     = '0;
    bus.pld_val_i = 1'b0;
    bus.pld_dat_i = '0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // IEND, zero-length payload.
    pbytes.delete();
    run_chunk(TYP_IEND, 1'b0, -1, 32'hAE42_6082);

    // IHDR 1x1, 8-bit greyscale.
    pbytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    run_chunk(TYP_IHDR, 1'b0, -1, 32'h3A7E_9B55);

    // IDAT 1000 bytes with random back-pressure and a stray start_i mid-payload.
    pbytes.delete();
    for (int i = 0; i < 1000; i++) pbytes.push_back(8'((i * 7 + 3) & 255));
    rand_rdy = 1'b1;
    run_chunk(TYP_IDAT, 1'b0, 10, chunk_crc(TYP_IDAT));
    rand_rdy = 1'b0;
    tick();

    // len=7 with payload bubbles: words 11223344/3 and 55667700/2.
    pbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_chunk(TYP_IDAT, 1'b1, -1, chunk_crc(TYP_IDAT));

    // Reset in the middle of a payload, then a clean IEND.
    pbytes.delete();
    for (int i = 0; i < 100; i++) pbytes.push_back(8'(i));
    d0 = done_cnt;
    start_chunk(TYP_IDAT);
    send_payload(5, 1'b0, -1);
    rstn = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    rstn = 1'b1;
    tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_done got %0d exp 0", done_cnt - d0);
    end
    pbytes.delete();
    run_chunk(TYP_IEND, 1'b0, -1, 32'hAE42_6082);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
